// File: rtl/toggle_level_decoder_if.sv
// toggle_level_decoder_if: level inputs and decoded pulse/count outputs of toggle_level_decoder
//   input_q_level / input_qbar_level : asynchronous Q and Qbar levels from the toggle source
//   output_level                      : debounced, accepted level
//   output_toggle/rise/fall_pulse     : 1-cycle pulses per accepted toggle
//   output_toggle_count               : wrap-around count of accepted toggles
//   output_count_wrap                 : 1-cycle pulse when the count wraps to 0
//   output_pair_error                 : sticky Q==Qbar fault flag
//   modport slave is the decoder side, modport master the source/consumer side.
interface toggle_level_decoder_if #(
    parameter int CNT_W = 8
);
    logic             input_q_level;
    logic             input_qbar_level;
    logic             output_level;
    logic             output_toggle_pulse;
    logic             output_rise_pulse;
    logic             output_fall_pulse;
    logic [CNT_W-1:0] output_toggle_count;
    logic             output_count_wrap;
    logic             output_pair_error;

    modport master (
        output input_q_level, input_qbar_level,
        input  output_level, output_toggle_pulse, output_rise_pulse, output_fall_pulse,
        input  output_toggle_count, output_count_wrap, output_pair_error
    );

    modport slave (
        input  input_q_level, input_qbar_level,
        output output_level, output_toggle_pulse, output_rise_pulse, output_fall_pulse,
        output output_toggle_count, output_count_wrap, output_pair_error
    );
endinterface

// File: rtl/toggle_level_decoder.sv
// toggle_level_decoder: synchronizes and debounces a toggle level, emitting one pulse per accepted change
//   input_clock    : single rising-edge clock
//   input_reset_n  : asynchronous active-low reset
//   bus            : toggle_level_decoder_if.slave (Q/Qbar levels in; level, pulses, count, wrap, pair error out)
//   Optional macro QBAR_CHECK_EN: adds a Qbar synchronizer and a sticky Q==Qbar pair check;
//   without it output_pair_error is tied low and input_qbar_level is ignored.
module toggle_level_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input logic                   input_clock,
    input logic                   input_reset_n,
    toggle_level_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, COMMIT} state_t;

    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    state_t           state, state_n;
    logic [1:0]       q_sync;
    logic             s;
    logic [7:0]       stab, stab_n;
    logic             commit;
    logic             level;
    logic             toggle_p, rise_p, fall_p, wrap_p;
    logic [CNT_W-1:0] count;

    assign s = q_sync[1];

    always_ff @(posedge input_clock or negedge input_reset_n)
        if (!input_reset_n)
            q_sync <= {2{RESET_LEVEL}};
        else
            q_sync <= {q_sync[0], bus.input_q_level};

    always_ff @(posedge input_clock or negedge input_reset_n)
        if (!input_reset_n) begin
            state <= IDLE;
            stab  <= '0;
        end else begin
            state <= state_n;
            stab  <= stab_n;
        end

    // A bounce is tested before the count limit so it always aborts the commit.
    always_comb begin
        state_n = state;
        stab_n  = stab;
        case (state)
            IDLE:
                if (s != level) begin
                    state_n = CHECK;
                    stab_n  = 8'd1;
                end
            CHECK:
                if (s == level) begin
                    state_n = IDLE;
                    stab_n  = '0;
                end else if (stab == SC)
                    state_n = COMMIT;
                else
                    stab_n = stab + 8'd1;
            default: begin
                state_n = IDLE;
                stab_n  = '0;
            end
        endcase
    end

    // Outputs are registered on the edge that enters COMMIT, so the pulse and the new level appear together.
    always_comb begin
        commit = state_n == COMMIT;
    end

    always_ff @(posedge input_clock or negedge input_reset_n)
        if (!input_reset_n) begin
            level    <= RESET_LEVEL;
            toggle_p <= 1'b0;
            rise_p   <= 1'b0;
            fall_p   <= 1'b0;
            wrap_p   <= 1'b0;
            count    <= '0;
        end else begin
            toggle_p <= commit;
            rise_p   <= commit && !level;
            fall_p   <= commit && level;
            wrap_p   <= commit && (&count);
            if (commit) begin
                level <= ~level;
                count <= count + CNT_W'(1);
            end
        end

    assign bus.output_level        = level;
    assign bus.output_toggle_pulse = toggle_p;
    assign bus.output_rise_pulse   = rise_p;
    assign bus.output_fall_pulse   = fall_p;
    assign bus.output_toggle_count = count;
    assign bus.output_count_wrap   = wrap_p;

`ifdef QBAR_CHECK_EN
    logic [1:0] qb_sync;
    logic [7:0] pair_run;
    logic       pair_err;

    // Qbar synchronizer resets to the complement so a fresh reset never looks like a pair fault.
    always_ff @(posedge input_clock or negedge input_reset_n)
        if (!input_reset_n) begin
            qb_sync  <= {2{~RESET_LEVEL}};
            pair_run <= '0;
            pair_err <= 1'b0;
        end else begin
            qb_sync  <= {qb_sync[0], bus.input_qbar_level};
            pair_run <= (s == qb_sync[1]) ? ((pair_run == SC) ? SC : pair_run + 8'd1) : '0;
            if (s == qb_sync[1] && pair_run >= SC - 8'd1)
                pair_err <= 1'b1;
        end

    assign bus.output_pair_error = pair_err;
`else
    logic unused_qbar;
    assign unused_qbar           = bus.input_qbar_level;
    assign bus.output_pair_error = 1'b0;
`endif
endmodule

// File: tb/tb_toggle_level_decoder.sv
// tb_toggle_level_decoder: table, directed and random checks of toggle_level_decoder against a run-length model
module tb_toggle_level_decoder;
    localparam int SA = 4, CA = 2, SB = 1, CB = 8;
    localparam int S_OF [2] = '{SA, SB};
    localparam int MOD  [2] = '{1 << CA, 1 << CB};
`ifdef QBAR_CHECK_EN
    localparam bit PAIR_ON = 1'b1;
`else
    localparam bit PAIR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic q = 1'b0;
    logic qb = 1'b1;
    always #5 clk = ~clk;

    toggle_level_decoder_if #(.CNT_W(CA)) ifa();
    toggle_level_decoder_if #(.CNT_W(CB)) ifb();
    assign ifa.input_q_level    = q;
    assign ifa.input_qbar_level = qb;
    assign ifb.input_q_level    = q;
    assign ifb.input_qbar_level = qb;

    toggle_level_decoder #(.STABLE_CYCLES(SA), .CNT_W(CA), .RESET_LEVEL(1'b0)) dut_a (
        .input_clock(clk), .input_reset_n(rst_n), .bus(ifa.slave));
    toggle_level_decoder #(.STABLE_CYCLES(SB), .CNT_W(CB), .RESET_LEVEL(1'b0)) dut_b (
        .input_clock(clk), .input_reset_n(rst_n), .bus(ifb.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a new level is accepted after S+1 consecutive differing synchronized
    // samples, then one sample is skipped; the synchronizer is a two-deep pin history.
    bit qh[$];
    bit bh[$];
    bit m_lvl [2], m_tog [2], m_rise [2], m_fall [2], m_wrap [2], m_err [2], blind [2];
    int m_cnt [2], run [2], pair_run [2];

    task automatic model_reset();
        qh = '{1'b0, 1'b0};
        bh = '{1'b1, 1'b1};
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = 0; m_tog[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_wrap[i] = 0;
            m_err[i] = 0; blind[i] = 0; m_cnt[i] = 0; run[i] = 0; pair_run[i] = 0;
        end
    endtask

    task automatic model_step();
        bit s, sb;
        s  = qh[0];
        sb = bh[0];
        for (int i = 0; i < 2; i++) begin
            m_tog[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_wrap[i] = 0;
            if (blind[i])
                blind[i] = 0;
            else if (s != m_lvl[i]) begin
                run[i]++;
                if (run[i] == S_OF[i] + 1) begin
                    m_lvl[i]  = s;
                    m_tog[i]  = 1;
                    m_rise[i] = s;
                    m_fall[i] = !s;
                    m_wrap[i] = (m_cnt[i] == MOD[i] - 1);
                    m_cnt[i]  = (m_cnt[i] + 1) % MOD[i];
                    run[i]    = 0;
                    blind[i]  = 1;
                end
            end else
                run[i] = 0;
            pair_run[i] = (s == sb) ? pair_run[i] + 1 : 0;
            if (PAIR_ON && pair_run[i] >= S_OF[i])
                m_err[i] = 1;
        end
        qh.push_back(q);
        void'(qh.pop_front());
        bh.push_back(qb);
        void'(bh.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    function automatic logic [13:0] pack(bit l, bit t, bit r, bit f, bit w, bit e, int c);
        return {l, t, r, f, w, e, 8'(c)};
    endfunction

    always @(negedge clk) begin
        logic [13:0] ga, gb, ea, eb;
        ga = pack(ifa.output_level, ifa.output_toggle_pulse, ifa.output_rise_pulse, ifa.output_fall_pulse,
                  ifa.output_count_wrap, ifa.output_pair_error, int'(ifa.output_toggle_count));
        gb = pack(ifb.output_level, ifb.output_toggle_pulse, ifb.output_rise_pulse, ifb.output_fall_pulse,
                  ifb.output_count_wrap, ifb.output_pair_error, int'(ifb.output_toggle_count));
        ea = pack(m_lvl[0], m_tog[0], m_rise[0], m_fall[0], m_wrap[0], m_err[0], m_cnt[0]);
        eb = pack(m_lvl[1], m_tog[1], m_rise[1], m_fall[1], m_wrap[1], m_err[1], m_cnt[1]);
        n_cmp += 2;
        if (ga !== ea) begin
            n_bad++;
            $display("FAIL model_a @%0t: got lvl/tog/rise/fall/wrap/err/cnt=%b want %b", $time, ga, ea);
        end
        if (gb !== eb) begin
            n_bad++;
            $display("FAIL model_b @%0t: got lvl/tog/rise/fall/wrap/err/cnt=%b want %b", $time, gb, eb);
        end
    end

    int seen_tog, seen_rise, seen_fall, seen_wrap;

    task automatic clear_seen();
        seen_tog = 0; seen_rise = 0; seen_fall = 0; seen_wrap = 0;
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(negedge clk);
            seen_tog  += int'(ifa.output_toggle_pulse);
            seen_rise += int'(ifa.output_rise_pulse);
            seen_fall += int'(ifa.output_fall_pulse);
            seen_wrap += int'(ifa.output_count_wrap);
        end
        #1;
    endtask

    task automatic chk(string name, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic set_q(bit v);
        q  = v;
        qb = ~v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit q;
        int hold;
        bit lvl;
        int cnt;
        int pulses;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b0, 8,  1'b0, 0, 0};
        tbl[1]  = '{1'b1, 10, 1'b1, 1, 1};
        tbl[2]  = '{1'b0, 4,  1'b1, 1, 0};
        tbl[3]  = '{1'b1, 10, 1'b1, 1, 0};
        tbl[4]  = '{1'b0, 5,  1'b1, 1, 0};
        tbl[5]  = '{1'b1, 12, 1'b1, 3, 2};
        tbl[6]  = '{1'b0, 7,  1'b0, 0, 1};
        tbl[7]  = '{1'b1, 6,  1'b0, 0, 0};
        tbl[8]  = '{1'b1, 3,  1'b1, 1, 1};
        tbl[9]  = '{1'b0, 1,  1'b1, 1, 0};
        tbl[10] = '{1'b1, 1,  1'b1, 1, 0};
        tbl[11] = '{1'b0, 1,  1'b1, 1, 0};
        tbl[12] = '{1'b1, 10, 1'b1, 1, 0};

        clear_seen();
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("reset_level", int'(ifa.output_level), 0);
        chk("reset_count", int'(ifa.output_toggle_count), 0);
        chk("reset_pulses", seen_tog, 0);
        chk("reset_count_b", int'(ifb.output_toggle_count), 0);

        clear_seen();
        set_q(1'b1);
        tick(3);
        set_q(1'b0);
        tick(12);
        chk("bounce_level", int'(ifa.output_level), 0);
        chk("bounce_count", int'(ifa.output_toggle_count), 0);
        chk("bounce_pulses", seen_tog, 0);

        set_q(1'b1);
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            chk($sformatf("lat_a_tog_e%0d", e), int'(ifa.output_toggle_pulse), int'(e == 7));
            chk($sformatf("lat_a_rise_e%0d", e), int'(ifa.output_rise_pulse), int'(e == 7));
            chk($sformatf("lat_b_tog_e%0d", e), int'(ifb.output_toggle_pulse), int'(e == 4));
        end
        chk("lat_level", int'(ifa.output_level), 1);
        chk("lat_count", int'(ifa.output_toggle_count), 1);

        set_q(1'b0);
        tick(10);
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            clear_seen();
            set_q(k[0]);
            tick(10);
            chk($sformatf("wrap_count_%0d", k), int'(ifa.output_toggle_count), k % 4);
            chk($sformatf("wrap_pulse_%0d", k), seen_wrap, int'(k == 4));
            chk($sformatf("wrap_fall_%0d", k), seen_fall, int'(k % 2 == 0));
            chk($sformatf("wrap_rise_%0d", k), seen_rise, int'(k % 2 == 1));
        end

        set_q(1'b1);
        tick(4);
        rst_n = 1'b0;
        clear_seen();
        tick(4);
        chk("rst_check_count", int'(ifa.output_toggle_count), 0);
        chk("rst_check_level", int'(ifa.output_level), 0);
        chk("rst_check_pulses", seen_tog, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            chk($sformatf("rst_rel_rise_e%0d", e), int'(ifa.output_rise_pulse), int'(e == 7));
        end
        chk("rst_rel_count", int'(ifa.output_toggle_count), 1);

        set_q(1'b0);
        tick(10);
        do_reset();
        for (int i = 0; i < 13; i++) begin
            clear_seen();
            set_q(tbl[i].q);
            tick(tbl[i].hold);
            chk($sformatf("tbl%0d_level", i), int'(ifa.output_level), int'(tbl[i].lvl));
            chk($sformatf("tbl%0d_count", i), int'(ifa.output_toggle_count), tbl[i].cnt);
            chk($sformatf("tbl%0d_pulses", i), seen_tog, tbl[i].pulses);
        end

        q  = 1'b1;
        qb = 1'b1;
        tick(4);
        qb = 1'b0;
        tick(6);
        chk("pair_set", int'(ifa.output_pair_error), int'(PAIR_ON));
        tick(10);
        chk("pair_sticky", int'(ifa.output_pair_error), int'(PAIR_ON));
        do_reset();
        chk("pair_cleared", int'(ifa.output_pair_error), 0);

        for (int n = 0; n < 250; n++) begin
            bit v;
            if ($urandom_range(0, 39) == 0) do_reset();
            v  = 1'($urandom_range(0, 1));
            q  = v;
            qb = ($urandom_range(0, 7) == 0) ? v : ~v;
            tick($urandom_range(1, 12));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
